// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the memory-port arbiter, its two requesters and the memory.
// master = arbiter side, slave = requesters/memory side.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ready;
   logic [DATA_W-1:0] if_rdata;

   logic              d_req;
   logic              d_we;
   logic [1:0]        d_size;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ready;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   logic              bus_err;

   modport master (
      input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_ack, mem_rdata,
      output if_ready, if_rdata, d_ready, d_rdata,
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata, bus_err
   );

   modport slave (
      output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_ack, mem_rdata,
      input  if_ready, if_rdata, d_ready, d_rdata,
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata, bus_err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by instruction fetch and load/store; data has fixed priority.
// Optional MEM_PORT_ARBITER_TIMEOUT_EN aborts an unacknowledged access after TIMEOUT cycles.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input logic                clk,
   input logic                rst,
   mem_port_arbiter_if.master bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_owner_d;
   logic [ADDR_W-1:0] r_addr;
   logic              r_we;
   logic [3:0]        r_be;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_d_rdata;

   logic              w_grant;
   logic              w_grant_d;
   logic              w_tmo;
   logic [ADDR_W-1:0] w_sel_addr;

   function automatic logic [3:0] byte_lanes(input logic [1:0] size, input logic [1:0] lane);
      logic [3:0] be;
      case (size)
         2'b00:   be = 4'b0001 << lane;
         2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   assign w_grant_d  = bus.d_req;
   assign w_grant    = bus.d_req | bus.if_req;
   assign w_sel_addr = w_grant_d ? bus.d_addr : bus.if_addr;

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_tmo;

   assign w_tmo = (r_state == ISSUE) && !bus.mem_ack && (r_cnt == CNT_W'(TIMEOUT - 1));

   // r_tmo marks the RESP cycle that follows an abort, so bus_err lines up with ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_tmo <= 1'b0;
      end else begin
         r_cnt <= (r_state == ISSUE) ? r_cnt + CNT_W'(1) : '0;
         r_tmo <= (r_state == ISSUE) ? w_tmo : 1'b0;
      end
   end

   assign bus.bus_err = (r_state == RESP) && r_tmo;
`else
   assign w_tmo       = 1'b0;
   assign bus.bus_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_grant) w_next = ISSUE;
         ISSUE:   if (bus.mem_ack || w_tmo) w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Grant is latched once in IDLE; everything driven to memory comes from these registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner_d  <= 1'b0;
         r_addr     <= '0;
         r_we       <= 1'b0;
         r_be       <= 4'b0000;
         r_wdata    <= '0;
         r_if_rdata <= '0;
         r_d_rdata  <= '0;
      end else begin
         if (r_state == IDLE && w_grant) begin
            r_owner_d <= w_grant_d;
            r_addr    <= {w_sel_addr[ADDR_W-1:2], 2'b00};
            r_we      <= w_grant_d & bus.d_we;
            r_be      <= w_grant_d ? byte_lanes(bus.d_size, w_sel_addr[1:0]) : 4'b1111;
            r_wdata   <= bus.d_wdata;
         end
         if (r_state == ISSUE && bus.mem_ack) begin
            if (r_owner_d) r_d_rdata  <= bus.mem_rdata;
            else           r_if_rdata <= bus.mem_rdata;
         end
      end
   end

   assign bus.mem_req   = (r_state == ISSUE);
   assign bus.mem_we    = r_we & (r_state == ISSUE);
   assign bus.mem_addr  = r_addr;
   assign bus.mem_be    = r_be;
   assign bus.mem_wdata = r_wdata;

   assign bus.if_ready  = (r_state == RESP) && !r_owner_d;
   assign bus.d_ready   = (r_state == RESP) && r_owner_d;
   assign bus.if_rdata  = r_if_rdata;
   assign bus.d_rdata   = r_d_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected memory transactions and responses are
// queued at issue time and consumed by independent monitors.
module tb_mem_port_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 64;
`endif

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } mtx_t;

   typedef struct packed {
      logic is_data;
      logic err;
   } rsp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if();

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   mtx_t        mq[$];
   rsp_t        rq[$];
   logic [31:0] dq[$];

   // responder controls
   bit          resp_en = 1'b1;
   int          force_delay = -1;
   bit          use_fixed = 1'b0;
   logic [31:0] fixed_rdata = 32'h0;
   bit          stale_pulse = 1'b0;

   // observations shared with the directed tests
   int          ready_cnt = 0;
   int          last_d_cyc = 0;
   int          last_if_cyc = 0;
   int          last_req_len = 0;
   logic [31:0] last_addr;
   logic        last_we;
   logic [3:0]  last_be;
   logic [31:0] last_if_m = 32'h0;
   logic [31:0] last_d_m = 32'h0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: a data access covers n=1/2/4 bytes in a naturally aligned slot of the word
   function automatic mtx_t model_data(input bit we, input logic [1:0] sz,
                                       input logic [31:0] a, input logic [31:0] wd);
      mtx_t m;
      int n, off, first;
      n     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      off   = int'(a % 4);
      first = off - (off % n);
      m.addr  = a - 32'(off);
      m.we    = we;
      m.wdata = wd;
      m.be    = 4'b0000;
      for (int i = 0; i < 4; i++)
         if (i >= first && i < first + n) m.be[i] = 1'b1;
      return m;
   endfunction

   function automatic mtx_t model_fetch(input logic [31:0] a);
      mtx_t m;
      m.addr  = a - (a % 4);
      m.we    = 1'b0;
      m.be    = 4'b1111;
      m.wdata = 32'h0;
      return m;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Memory responder
   initial begin
      bit          active;
      int          wcnt, delay;
      logic [31:0] rd;
      active = 1'b0;
      wcnt = 0;
      delay = 0;
      bus_if.mem_ack   = 1'b0;
      bus_if.mem_rdata = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         bus_if.mem_ack   = 1'b0;
         bus_if.mem_rdata = $urandom;
         if (stale_pulse) begin
            bus_if.mem_ack = 1'b1;
            stale_pulse = 1'b0;
         end else if (resp_en && bus_if.mem_req) begin
            if (!active) begin
               active = 1'b1;
               wcnt = 0;
               delay = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 5));
            end
            if (wcnt == delay) begin
               rd = use_fixed ? fixed_rdata : $urandom;
               bus_if.mem_ack   = 1'b1;
               bus_if.mem_rdata = rd;
               dq.push_back(rd);
               active = 1'b0;
            end else begin
               wcnt++;
            end
         end else begin
            active = 1'b0;
         end
      end
   end

   // Memory-side monitor
   initial begin
      logic        prev_req;
      int          req_len;
      mtx_t        e;
      logic [31:0] cap_addr, cap_wd;
      logic        cap_we;
      logic [3:0]  cap_be;
      prev_req = 1'b0;
      req_len = 0;
      forever begin
         @(negedge clk);
         if (bus_if.mem_req) begin
            if (!prev_req) begin
               req_len = 1;
               cap_addr = bus_if.mem_addr;
               cap_we   = bus_if.mem_we;
               cap_be   = bus_if.mem_be;
               cap_wd   = bus_if.mem_wdata;
               last_addr = cap_addr;
               last_we   = cap_we;
               last_be   = cap_be;
               if (mq.size() == 0) begin
                  chk("mem_req_unexpected", 1, 0);
               end else begin
                  e = mq.pop_front();
                  chk("mem_addr", bus_if.mem_addr, e.addr);
                  chk("mem_we", bus_if.mem_we, e.we);
                  chk("mem_be", bus_if.mem_be, e.be);
                  if (e.we) chk("mem_wdata", bus_if.mem_wdata, e.wdata);
               end
            end else begin
               req_len++;
               chk("mem_hold_addr", bus_if.mem_addr, cap_addr);
               chk("mem_hold_ctl", {bus_if.mem_we, bus_if.mem_be, bus_if.mem_wdata},
                   {cap_we, cap_be, cap_wd});
            end
         end else if (prev_req) begin
            last_req_len = req_len;
         end
         prev_req = bus_if.mem_req;
      end
   end

   // Requester-side monitor
   initial begin
      logic        prev_ir, prev_dr;
      rsp_t        e;
      logic [31:0] rd;
      prev_ir = 1'b0;
      prev_dr = 1'b0;
      forever begin
         @(negedge clk);
         if (bus_if.if_ready && bus_if.d_ready) chk("both_ready", 1, 0);
         if (prev_ir && bus_if.if_ready) chk("if_ready_pulse", 1, 0);
         if (prev_dr && bus_if.d_ready) chk("d_ready_pulse", 1, 0);
         if (bus_if.if_ready || bus_if.d_ready) begin
            ready_cnt++;
            if (bus_if.d_ready) last_d_cyc = cyc;
            else                last_if_cyc = cyc;
            if (rq.size() == 0) begin
               chk("ready_unexpected", 1, 0);
            end else begin
               e = rq.pop_front();
               chk("ready_owner", bus_if.d_ready, e.is_data);
               chk("bus_err", bus_if.bus_err, e.err);
               if (dq.size() == 0) begin
                  chk("rdata_missing", 1, 0);
               end else begin
                  rd = dq.pop_front();
                  if (e.is_data) begin
                     chk("d_rdata", bus_if.d_rdata, rd);
                     last_d_m = rd;
                  end else begin
                     chk("if_rdata", bus_if.if_rdata, rd);
                     last_if_m = rd;
                  end
               end
            end
         end else begin
            if (!rst) begin
               chk("if_rdata_hold", bus_if.if_rdata, last_if_m);
               chk("d_rdata_hold", bus_if.d_rdata, last_d_m);
            end
            if (bus_if.bus_err) chk("bus_err_alone", 1, 0);
         end
         prev_ir = bus_if.if_ready;
         prev_dr = bus_if.d_ready;
      end
   end

   task automatic run_txn(input bit do_if, input bit do_d, input logic [31:0] ia,
                          input bit we, input logic [1:0] sz, input logic [31:0] da,
                          input logic [31:0] wd, input bit early_drop);
      bit dp, ip, drop_d;
      @(posedge clk);
      #1;
      drop_d = 1'b0;
      if (do_d) begin
         bus_if.d_we    = we;
         bus_if.d_size  = sz;
         bus_if.d_addr  = da;
         bus_if.d_wdata = wd;
         bus_if.d_req   = 1'b1;
         mq.push_back(model_data(we, sz, da, wd));
         rq.push_back('{1'b1, 1'b0});
      end
      if (do_if) begin
         bus_if.if_addr = ia;
         bus_if.if_req  = 1'b1;
         mq.push_back(model_fetch(ia));
         rq.push_back('{1'b0, 1'b0});
      end
      dp = do_d;
      ip = do_if;
      for (int c = 0; c < 200 && (dp || ip); c++) begin
         @(negedge clk);
         if (bus_if.d_ready) dp = 1'b0;
         if (bus_if.if_ready) ip = 1'b0;
         if (early_drop && bus_if.mem_req) drop_d = 1'b1;
         @(posedge clk);
         #1;
         if (!dp || drop_d) bus_if.d_req = 1'b0;
         if (!ip) bus_if.if_req = 1'b0;
      end
      if (dp || ip) begin
         chk("txn_timeout", 1, 0);
         bus_if.d_req  = 1'b0;
         bus_if.if_req = 1'b0;
      end
   endtask

   initial begin
      #200us;
      chk("watchdog", 1, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      int   rc0, n;
      int   kind;
      rst = 1'b1;
      bus_if.if_req  = 1'b0;
      bus_if.if_addr = 32'h0;
      bus_if.d_req   = 1'b0;
      bus_if.d_we    = 1'b0;
      bus_if.d_size  = 2'b00;
      bus_if.d_addr  = 32'h0;
      bus_if.d_wdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_req", bus_if.mem_req, 0);
      chk("rst_mem_we", bus_if.mem_we, 0);
      chk("rst_mem_addr", bus_if.mem_addr, 0);
      chk("rst_mem_be", bus_if.mem_be, 0);
      chk("rst_mem_wdata", bus_if.mem_wdata, 0);
      chk("rst_ready", {bus_if.if_ready, bus_if.d_ready, bus_if.bus_err}, 0);
      chk("rst_rdata", {bus_if.if_rdata, bus_if.d_rdata}, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // single fetch with fixed memory data
      force_delay = 0;
      use_fixed = 1'b1;
      fixed_rdata = 32'hE3A00001;
      rc0 = ready_cnt;
      run_txn(1'b1, 1'b0, 32'h100, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0);
      use_fixed = 1'b0;
      chk("fetch_rdata", bus_if.if_rdata, 32'hE3A00001);
      chk("fetch_addr", last_addr, 32'h100);
      chk("fetch_be", last_be, 4'b1111);
      chk("fetch_one_ready", ready_cnt - rc0, 1);

      // simultaneous requests: data first, fetch three cycles later
      run_txn(1'b1, 1'b1, 32'h440, 1'b0, 2'd2, 32'h2000, 32'h0, 1'b0);
      chk("fetch_after_data", last_if_cyc - last_d_cyc, 3);

      // byte store (req dropped early), then halfword store
      run_txn(1'b0, 1'b1, 32'h0, 1'b1, 2'd0, 32'h2003, 32'h5A5A5A5A, 1'b1);
      chk("bstore_addr", last_addr, 32'h2000);
      chk("bstore_be", last_be, 4'b1000);
      chk("bstore_we", last_we, 1);
      run_txn(1'b0, 1'b1, 32'h0, 1'b1, 2'd1, 32'h2002, 32'h12341234, 1'b0);
      chk("hstore_be", last_be, 4'b1100);

      // slow memory
      force_delay = 5;
      rc0 = ready_cnt;
      run_txn(1'b0, 1'b1, 32'h0, 1'b0, 2'd2, 32'h2010, 32'h0, 1'b0);
      chk("slow_req_len", last_req_len, 6);
      chk("slow_one_ready", ready_cnt - rc0, 1);
      force_delay = -1;

      // reset during ISSUE, then a stale ack
      resp_en = 1'b0;
      @(posedge clk);
      #1;
      bus_if.d_we = 1'b0;
      bus_if.d_size = 2'd2;
      bus_if.d_addr = 32'h3000;
      bus_if.d_req = 1'b1;
      mq.push_back(model_data(1'b0, 2'd2, 32'h3000, 32'h0));
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus_if.mem_req) break;
      end
      chk("rst_test_req_up", bus_if.mem_req, 1);
      #2;
      rst = 1'b1;
      last_if_m = 32'h0;
      last_d_m = 32'h0;
      #1;
      chk("rst_async_req", bus_if.mem_req, 0);
      chk("rst_async_addr", bus_if.mem_addr, 0);
      bus_if.d_req = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      rc0 = ready_cnt;
      stale_pulse = 1'b1;
      repeat (5) @(negedge clk);
      chk("stale_ack_ready", ready_cnt - rc0, 0);
      chk("stale_ack_req", bus_if.mem_req, 0);
      resp_en = 1'b1;
      run_txn(1'b0, 1'b1, 32'h0, 1'b0, 2'd2, 32'h3004, 32'h0, 1'b0);
      run_txn(1'b1, 1'b0, 32'h3008, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0);

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
      // unanswered load aborts with bus_err alongside d_ready; d_rdata keeps its old value
      resp_en = 1'b0;
      @(posedge clk);
      #1;
      bus_if.d_we = 1'b0;
      bus_if.d_size = 2'd2;
      bus_if.d_addr = 32'h4000;
      bus_if.d_req = 1'b1;
      mq.push_back(model_data(1'b0, 2'd2, 32'h4000, 32'h0));
      rq.push_back('{1'b1, 1'b1});
      dq.push_back(last_d_m);
      n = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus_if.mem_req) n++;
         if (bus_if.d_ready) break;
      end
      chk("tmo_issue_cycles", n, 8);
      @(posedge clk);
      #1 bus_if.d_req = 1'b0;
      resp_en = 1'b1;
`endif

      // randomized mix
      for (int i = 0; i < 60; i++) begin
         kind = int'($urandom_range(0, 2));
         run_txn(kind != 1, kind != 0, $urandom, 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), $urandom, $urandom, 1'b0);
      end

      repeat (5) @(negedge clk);
      chk("mq_drained", mq.size(), 0);
      chk("rq_drained", rq.size(), 0);
      chk("dq_drained", dq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
